// File: rtl/hazard_pkg.sv
// Shared FSM encoding and forward-select codes for the pipeline hazard logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MC_BUSY  = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hazard_state_t;

    // ID/EX operand source selects.
    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_EXMEM   = 2'b01;
    localparam logic [1:0] FWD_MEMWB   = 2'b10;

endpackage

// File: rtl/fwd_select_unit.sv
// Forward-select for one ID source operand; EX/MEM result wins over MEM/WB.
// Latency: purely combinational.
// Backpressure: none; the select is captured only when ID/EX is enabled.
// Ports: i_rs (operand index), i_ex_rd/i_ex_reg_write, i_mem_rd/i_mem_reg_write,
//        o_sel (00 regfile, 01 EX/MEM, 10 MEM/WB).
module fwd_select_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_reg_write,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic                  i_mem_reg_write,
    output logic [1:0]            o_sel
);

    logic w_ex_hit;
    logic w_mem_hit;

    // x0 is hard-wired zero, so a write to it never produces a forwardable value.
    assign w_ex_hit  = i_ex_reg_write  && (i_ex_rd  != '0) && (i_ex_rd  == i_rs);
    assign w_mem_hit = i_mem_reg_write && (i_mem_rd != '0) && (i_mem_rd == i_rs);

    always_comb begin
        o_sel = FWD_REGFILE;
        if (w_ex_hit) begin
            o_sel = FWD_EXMEM;
        end else if (w_mem_hit) begin
            o_sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencer: PC/IF-ID/ID-EX/EX-MEM enables and flushes, ID forward selects, stall counter.
// Latency: all enables, flushes and selects are combinational from state and inputs.
// Backpressure: dmem_ready=0 freezes every stage; multi-cycle EX ops and load-use freeze upstream.
// Ports: i_clk, i_rst_n (sync, active-low); ID operands i_id_rs*/i_id_rs*_used; EX/MEM
//        destinations and write/load flags; i_ex_mc_start/i_ex_mc_cycles; i_branch_taken;
//        i_dmem_ready; outputs o_*_en, o_*_flush, o_exmem_bubble, o_fwd_rs*_sel, o_busy,
//        o_stall_count.
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int MC_CNT_W   = 6,
    parameter int PERF_W     = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic                  i_id_rs1_used,
    input  logic                  i_id_rs2_used,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_reg_write,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_mem_rd,
    input  logic                  i_mem_reg_write,
    input  logic                  i_ex_mc_start,
    input  logic [MC_CNT_W-1:0]   i_ex_mc_cycles,
    input  logic                  i_branch_taken,
    input  logic                  i_dmem_ready,
    output logic                  o_pc_en,
    output logic                  o_ifid_en,
    output logic                  o_idex_en,
    output logic                  o_exmem_en,
    output logic                  o_ifid_flush,
    output logic                  o_idex_flush,
    output logic                  o_exmem_bubble,
    output logic [1:0]            o_fwd_rs1_sel,
    output logic [1:0]            o_fwd_rs2_sel,
    output logic                  o_busy,
    output logic [PERF_W-1:0]     o_stall_count
);

    hazard_state_t         r_state;
    hazard_state_t         w_state_nxt;
    hazard_state_t         w_eff_state;
    logic [MC_CNT_W-1:0]   r_mc_cnt;
    logic [MC_CNT_W-1:0]   w_mc_cnt_nxt;
    logic [PERF_W-1:0]     r_stall_count;

    logic                  w_pc_en;
    logic                  w_ifid_en;
    logic                  w_idex_en;
    logic                  w_exmem_en;
    logic                  w_ifid_flush;
    logic                  w_idex_flush;
    logic                  w_exmem_bubble;
    logic                  w_load_use;
    logic                  w_mc_long;
    logic [MC_CNT_W-1:0]   w_mc_rem;
    logic [1:0]            w_fwd_rs1;
    logic [1:0]            w_fwd_rs2;

    fwd_select_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .i_rs            (i_id_rs1),
        .i_ex_rd         (i_ex_rd),
        .i_ex_reg_write  (i_ex_reg_write),
        .i_mem_rd        (i_mem_rd),
        .i_mem_reg_write (i_mem_reg_write),
        .o_sel           (w_fwd_rs1)
    );

    fwd_select_unit #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .i_rs            (i_id_rs2),
        .i_ex_rd         (i_ex_rd),
        .i_ex_reg_write  (i_ex_reg_write),
        .i_mem_rd        (i_mem_rd),
        .i_mem_reg_write (i_mem_reg_write),
        .o_sel           (w_fwd_rs2)
    );

    assign w_load_use = i_ex_mem_read && (i_ex_rd != '0) &&
                        ((i_id_rs1_used && (i_id_rs1 == i_ex_rd)) ||
                         (i_id_rs2_used && (i_id_rs2 == i_ex_rd)));

    // r_mc_cnt holds the number of MC_BUSY cycles still to spend frozen. The start
    // cycle is itself a frozen cycle, so an N-cycle op needs N-2 MC_BUSY cycles
    // and the PC is held for N-1 cycles; the result is captured on the next RUN cycle.
    assign w_mc_long = i_ex_mc_start && (i_ex_mc_cycles >= MC_CNT_W'(2));
    assign w_mc_rem  = i_ex_mc_cycles - MC_CNT_W'(2);

    // Leaving a memory wait resumes whatever was interrupted, in the same cycle.
    assign w_eff_state = (r_state == ST_MEM_WAIT) ?
                         ((r_mc_cnt != '0) ? ST_MC_BUSY : ST_RUN) : r_state;

    always_comb begin
        w_pc_en        = 1'b1;
        w_ifid_en      = 1'b1;
        w_idex_en      = 1'b1;
        w_exmem_en     = 1'b1;
        w_ifid_flush   = 1'b0;
        w_idex_flush   = 1'b0;
        w_exmem_bubble = 1'b0;
        w_state_nxt    = r_state;
        w_mc_cnt_nxt   = r_mc_cnt;

        if (!i_rst_n) begin
            w_pc_en      = 1'b0;
            w_ifid_en    = 1'b0;
            w_idex_en    = 1'b0;
            w_exmem_en   = 1'b0;
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
            w_state_nxt  = ST_RUN;
            w_mc_cnt_nxt = '0;
        end else if (!i_dmem_ready) begin
            // Full freeze; the multi-cycle countdown is parked, not lost.
            w_pc_en     = 1'b0;
            w_ifid_en   = 1'b0;
            w_idex_en   = 1'b0;
            w_exmem_en  = 1'b0;
            w_state_nxt = ST_MEM_WAIT;
        end else begin
            case (w_eff_state)
                ST_MC_BUSY: begin
                    w_pc_en        = 1'b0;
                    w_ifid_en      = 1'b0;
                    w_idex_en      = 1'b0;
                    w_exmem_bubble = 1'b1;
                    if (r_mc_cnt <= MC_CNT_W'(1)) begin
                        w_state_nxt  = ST_RUN;
                        w_mc_cnt_nxt = '0;
                    end else begin
                        w_state_nxt  = ST_MC_BUSY;
                        w_mc_cnt_nxt = r_mc_cnt - MC_CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = ST_RUN;
                    if (w_mc_long) begin
                        w_pc_en        = 1'b0;
                        w_ifid_en      = 1'b0;
                        w_idex_en      = 1'b0;
                        w_exmem_bubble = 1'b1;
                        w_mc_cnt_nxt   = w_mc_rem;
                        // A 2-cycle op is fully covered by the start cycle alone.
                        w_state_nxt    = (w_mc_rem != '0) ? ST_MC_BUSY : ST_RUN;
                    end else if (i_branch_taken) begin
                        w_ifid_flush = 1'b1;
                        w_idex_flush = 1'b1;
                    end else if (w_load_use) begin
                        w_pc_en      = 1'b0;
                        w_ifid_en    = 1'b0;
                        w_idex_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_RUN;
            r_mc_cnt      <= '0;
            r_stall_count <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mc_cnt <= w_mc_cnt_nxt;
            if (!w_pc_en && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + PERF_W'(1);
            end
        end
    end

    assign o_pc_en        = w_pc_en;
    assign o_ifid_en      = w_ifid_en;
    assign o_idex_en      = w_idex_en;
    assign o_exmem_en     = w_exmem_en;
    assign o_ifid_flush   = w_ifid_flush;
    assign o_idex_flush   = w_idex_flush;
    assign o_exmem_bubble = w_exmem_bubble;
    assign o_fwd_rs1_sel  = i_rst_n ? w_fwd_rs1 : FWD_REGFILE;
    assign o_fwd_rs2_sel  = i_rst_n ? w_fwd_rs2 : FWD_REGFILE;
    assign o_busy         = i_rst_n && (r_state != ST_RUN);
    assign o_stall_count  = r_stall_count;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller with an expected-output queue.
// Latency: each step drives inputs after a rising edge and checks before the next one.
// Backpressure: n/a.
module tb_hazard_stall_controller;

    typedef struct packed {
        logic       pc_en;
        logic       ifid_en;
        logic       idex_en;
        logic       exmem_en;
        logic       ifid_flush;
        logic       idex_flush;
        logic       exmem_bubble;
        logic [1:0] f1;
        logic [1:0] f2;
        logic       busy;
    } ctl_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd, mem_rd;
    logic        id_rs1_used, id_rs2_used, ex_reg_write, ex_mem_read, mem_reg_write;
    logic        ex_mc_start, branch_taken, dmem_ready;
    logic [5:0]  ex_mc_cycles;
    logic        pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, exmem_bubble, busy;
    logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
    logic [31:0] stall_count;

    ctl_t        exp_q[$];
    string       tag_q[$];
    logic [31:0] exp_stall = '0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    hazard_stall_controller dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_id_rs1       (id_rs1),
        .i_id_rs2       (id_rs2),
        .i_id_rs1_used  (id_rs1_used),
        .i_id_rs2_used  (id_rs2_used),
        .i_ex_rd        (ex_rd),
        .i_ex_reg_write (ex_reg_write),
        .i_ex_mem_read  (ex_mem_read),
        .i_mem_rd       (mem_rd),
        .i_mem_reg_write(mem_reg_write),
        .i_ex_mc_start  (ex_mc_start),
        .i_ex_mc_cycles (ex_mc_cycles),
        .i_branch_taken (branch_taken),
        .i_dmem_ready   (dmem_ready),
        .o_pc_en        (pc_en),
        .o_ifid_en      (ifid_en),
        .o_idex_en      (idex_en),
        .o_exmem_en     (exmem_en),
        .o_ifid_flush   (ifid_flush),
        .o_idex_flush   (idex_flush),
        .o_exmem_bubble (exmem_bubble),
        .o_fwd_rs1_sel  (fwd_rs1_sel),
        .o_fwd_rs2_sel  (fwd_rs2_sel),
        .o_busy         (busy),
        .o_stall_count  (stall_count)
    );

    function automatic ctl_t mk(input logic pc, input logic ifd, input logic idx, input logic exm,
                                input logic ifl, input logic idl, input logic bub,
                                input logic [1:0] s1, input logic [1:0] s2, input logic bsy);
        ctl_t c;
        c = {pc, ifd, idx, exm, ifl, idl, bub, s1, s2, bsy};
        return c;
    endfunction

    task automatic idle_inputs();
        rst_n = 1'b1;
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0;
        mem_rd = 5'd0; mem_reg_write = 1'b0;
        ex_mc_start = 1'b0; ex_mc_cycles = 6'd0; branch_taken = 1'b0; dmem_ready = 1'b1;
    endtask

    // Inputs are already driven; queue the expectation, check at the falling edge,
    // then advance the stall-count model across the rising edge.
    task automatic step(input string tag, input ctl_t e);
        ctl_t  ex;
        ctl_t  obs;
        string tg;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        ex  = exp_q.pop_front();
        tg  = tag_q.pop_front();
        obs = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, exmem_bubble,
               fwd_rs1_sel, fwd_rs2_sel, busy};
        checks++;
        assert (obs === ex) else begin
            failures++;
            $display("FAIL %s ctl observed=%b expected=%b", tg, obs, ex);
            $error("%s control outputs differ", tg);
        end
        checks++;
        assert (stall_count === exp_stall) else begin
            failures++;
            $display("FAIL %s stall_count observed=%0d expected=%0d", tg, stall_count, exp_stall);
            $error("%s stall count differs", tg);
        end
        @(posedge clk);
        if (!rst_n) exp_stall = '0;
        else if (!ex.pc_en && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 32'd1;
        #1;
    endtask

    initial begin
        idle_inputs();
        // Reset with a live forwarding match: selects must still read 00.
        rst_n = 1'b0; ex_rd = 5'd5; ex_reg_write = 1'b1; id_rs1 = 5'd5;
        step("reset0", mk(0,0,0,0,1,1,0,2'b00,2'b00,0));
        step("reset1", mk(0,0,0,0,1,1,0,2'b00,2'b00,0));

        idle_inputs();
        step("idle", mk(1,1,1,1,0,0,0,2'b00,2'b00,0));

        // Forwarding.
        ex_rd = 5'd5; ex_reg_write = 1'b1; mem_rd = 5'd5; mem_reg_write = 1'b1;
        id_rs1 = 5'd5; id_rs1_used = 1'b1; id_rs2 = 5'd3;
        step("fwd_ex_prio", mk(1,1,1,1,0,0,0,2'b01,2'b00,0));
        ex_rd = 5'd0; id_rs1 = 5'd0; mem_reg_write = 1'b0;
        step("fwd_rd0", mk(1,1,1,1,0,0,0,2'b00,2'b00,0));
        ex_rd = 5'd0; mem_reg_write = 1'b1; id_rs1 = 5'd5;
        step("fwd_ex_rd0_mem", mk(1,1,1,1,0,0,0,2'b10,2'b00,0));
        ex_rd = 5'd9; ex_reg_write = 1'b0; id_rs2 = 5'd9; mem_rd = 5'd4; id_rs1 = 5'd4;
        step("fwd_nowrite", mk(1,1,1,1,0,0,0,2'b10,2'b00,0));

        // Load-use on rs2.
        idle_inputs();
        ex_rd = 5'd7; ex_reg_write = 1'b1; ex_mem_read = 1'b1; id_rs2 = 5'd7; id_rs2_used = 1'b1;
        step("loaduse", mk(0,0,1,1,0,1,0,2'b00,2'b01,0));
        idle_inputs();
        mem_rd = 5'd7; mem_reg_write = 1'b1; id_rs2 = 5'd7; id_rs2_used = 1'b1;
        step("loaduse_after", mk(1,1,1,1,0,0,0,2'b00,2'b10,0));
        idle_inputs();
        ex_rd = 5'd7; ex_reg_write = 1'b1; ex_mem_read = 1'b1; id_rs2 = 5'd7;
        step("load_unused", mk(1,1,1,1,0,0,0,2'b00,2'b01,0));

        // 4-cycle op: PC frozen 3 cycles.
        idle_inputs();
        ex_mc_start = 1'b1; ex_mc_cycles = 6'd4;
        step("mc4_start", mk(0,0,0,1,0,0,1,2'b00,2'b00,0));
        idle_inputs();
        step("mc4_b1", mk(0,0,0,1,0,0,1,2'b00,2'b00,1));
        step("mc4_b2", mk(0,0,0,1,0,0,1,2'b00,2'b00,1));
        step("mc4_done", mk(1,1,1,1,0,0,0,2'b00,2'b00,0));
        ex_mc_start = 1'b1; ex_mc_cycles = 6'd1;
        step("mc1", mk(1,1,1,1,0,0,0,2'b00,2'b00,0));
        idle_inputs();
        step("mc1_after", mk(1,1,1,1,0,0,0,2'b00,2'b00,0));

        // Memory wait during MC_BUSY with one busy cycle left: 3+2 freeze.
        ex_mc_start = 1'b1; ex_mc_cycles = 6'd4;
        step("mw_start", mk(0,0,0,1,0,0,1,2'b00,2'b00,0));
        idle_inputs();
        step("mw_b1", mk(0,0,0,1,0,0,1,2'b00,2'b00,1));
        dmem_ready = 1'b0;
        step("mw_wait1", mk(0,0,0,0,0,0,0,2'b00,2'b00,1));
        step("mw_wait2", mk(0,0,0,0,0,0,0,2'b00,2'b00,1));
        dmem_ready = 1'b1;
        step("mw_resume", mk(0,0,0,1,0,0,1,2'b00,2'b00,1));
        step("mw_done", mk(1,1,1,1,0,0,0,2'b00,2'b00,0));

        // Memory wait from RUN returns straight to RUN outputs.
        dmem_ready = 1'b0;
        step("rw_wait", mk(0,0,0,0,0,0,0,2'b00,2'b00,0));
        dmem_ready = 1'b1;
        step("rw_resume", mk(1,1,1,1,0,0,0,2'b00,2'b00,1));
        step("rw_done", mk(1,1,1,1,0,0,0,2'b00,2'b00,0));

        // Branch overrides load-use.
        ex_rd = 5'd7; ex_reg_write = 1'b1; ex_mem_read = 1'b1; id_rs1 = 5'd7; id_rs1_used = 1'b1;
        branch_taken = 1'b1;
        step("branch_lu", mk(1,1,1,1,1,1,0,2'b01,2'b00,0));

        // Reset in the second MC_BUSY cycle of a 10-cycle op.
        idle_inputs();
        ex_mc_start = 1'b1; ex_mc_cycles = 6'd10;
        step("rst_mc_start", mk(0,0,0,1,0,0,1,2'b00,2'b00,0));
        idle_inputs();
        step("rst_mc_b1", mk(0,0,0,1,0,0,1,2'b00,2'b00,1));
        rst_n = 1'b0;
        step("rst_mc_reset", mk(0,0,0,0,1,1,0,2'b00,2'b00,0));
        rst_n = 1'b1;
        step("rst_mc_rel1", mk(1,1,1,1,0,0,0,2'b00,2'b00,0));
        step("rst_mc_rel2", mk(1,1,1,1,0,0,0,2'b00,2'b00,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
